// File: rtl/la_readout_engine.sv
`default_nettype none
// ============================================================================
// Module   : la_readout_engine
// Purpose  : Walks the logic-analyzer capture buffer after capture completes and
//            serialises each capture word into OUT_W-bit valid/ready beats.
// Revision : 1.0 - initial release
// ============================================================================
module la_readout_engine #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 256,
    parameter int OUT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [2:0]          la_status,
    output logic [ADDR_W-1:0]   la_read_addr,
    input  logic [DATA_W-1:0]   la_dout,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [ADDR_W+2:0]   beat_index,
    output logic                busy,
    output logic                done
);

    localparam int LANES  = DATA_W / OUT_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BEAT_W = ADDR_W + 3;

    localparam logic [2:0]        CAP_DONE  = 3'b100;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CAP = 3'd1,
        S_FETCH    = 3'd2,
        S_LATCH    = 3'd3,
        S_STREAM   = 3'd4,
        S_COMPLETE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [LANE_W-1:0]   lane_q,  lane_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   shift_q, shift_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT_CAP;
            end
            S_WAIT_CAP: begin
                if (la_status == CAP_DONE) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    lane_d  = '0;
                    beat_d  = '0;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shift_d = la_dout;
                valid_d = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (valid_q && out_ready) begin
                    if (lane_q != LAST_LANE) begin
                        lane_d  = lane_q + LANE_W'(1);
                        beat_d  = beat_q + BEAT_W'(1);
                        shift_d = shift_q >> OUT_W;
                    end else if (addr_q != LAST_ADDR) begin
                        valid_d = 1'b0;
                        addr_d  = addr_q + ADDR_W'(1);
                        lane_d  = '0;
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        // beat_index parks at its final value until the next readout
                        valid_d = 1'b0;
                        addr_d  = '0;
                        lane_d  = '0;
                        state_d = S_COMPLETE;
                    end
                end
            end
            S_COMPLETE: begin
                addr_d = '0;
                if (start) state_d = S_WAIT_CAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel wins over every other request, including an in-flight transfer
        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            addr_d  = '0;
            beat_d  = '0;
            lane_d  = '0;
        end
    end

    assign la_read_addr = addr_q;
    assign out_data     = shift_q[OUT_W-1:0];
    assign out_valid    = valid_q;
    assign out_last     = valid_q && (addr_q == LAST_ADDR) && (lane_q == LAST_LANE);
    assign beat_index   = beat_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_COMPLETE);
    assign done         = (state_q == S_COMPLETE);

endmodule
`default_nettype wire

// File: tb/tb_la_readout_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_readout_engine
// Purpose  : Directed self-checking bench for la_readout_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_la_readout_engine;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int DATA_W = 256;
    localparam int OUT_W  = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic [2:0]          la_status;
    logic [ADDR_W-1:0]   la_read_addr;
    logic [DATA_W-1:0]   la_dout;
    logic [OUT_W-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [ADDR_W+2:0]   beat_index;
    logic                busy;
    logic                done;

    logic [DATA_W-1:0]   mem [DEPTH];

    int checks = 0;
    int errors = 0;

    la_readout_engine #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .la_status(la_status), .la_read_addr(la_read_addr), .la_dout(la_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .beat_index(beat_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Capture buffer with one-cycle read latency
    always_ff @(posedge clk) la_dout <= mem[la_read_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_beat(input int n);
        logic [8:0] b;
        b = n[8:0];
        return {b[8:3], 23'd0, b[2:0]};
    endfunction

    // Consumes beats until 512 transfers (or stop_at is presented), scoring every transfer
    task automatic run_stream(input bit rnd, input int stop_at, input bit drop_status,
                              input int start_pulse_at, output int nb);
        int cyc = 0;
        int t7 = -1;
        int t8 = -1;
        int bad_data = 0;
        int bad_idx = 0;
        int bad_last = 0;
        int bad_hold = 0;
        bit pstall = 0;
        bit pulsed = 0;
        logic [31:0] pd = '0;
        logic [8:0]  pi = '0;
        nb = 0;
        while (nb < 512 && cyc < 4000) begin
            if (stop_at >= 0 && out_valid && beat_index == stop_at[8:0]) break;
            if (pstall && (out_data !== pd || beat_index !== pi || !out_valid)) bad_hold++;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            start = (start_pulse_at >= 0 && nb == start_pulse_at && !pulsed);
            if (start) pulsed = 1;
            if (drop_status && nb >= 1) la_status = 3'b000;
            if (!out_valid && out_last) bad_last++;
            if (out_valid && out_ready) begin
                if (out_data !== exp_beat(nb)) bad_data++;
                if (beat_index !== nb[8:0]) bad_idx++;
                if (out_last !== (nb == 511)) bad_last++;
                if (nb == 7) t7 = cyc;
                if (nb == 8) t8 = cyc;
                nb++;
                pstall = 0;
            end else if (out_valid) begin
                pstall = 1;
                pd = out_data;
                pi = beat_index;
            end else begin
                pstall = 0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("beat_data_mismatches", bad_data, 0);
        check("beat_index_mismatches", bad_idx, 0);
        check("out_last_mismatches", bad_last, 0);
        if (rnd) check("stall_hold_violations", bad_hold, 0);
        if (stop_at < 0) check("beat_count", nb, 512);
        if (!rnd && stop_at < 0) check("word_gap_cycles", t8 - t7, 3);
    endtask

    task automatic check_complete(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_addr"}, la_read_addr, 0);
        check({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        int nb;
        int bad;
        for (int n = 0; n < DEPTH; n++)
            for (int k = 0; k < DATA_W / OUT_W; k++)
                mem[n][32*k +: 32] = {6'(n), 26'(k)};

        reset = 1'b1; start = 1'b0; abort = 1'b0; la_status = 3'b000; out_ready = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_addr", la_read_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_beat_index", beat_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        step(); step();
        reset = 1'b0;
        step();

        // Start while capture is still armed; nothing may stream until DONE
        la_status = 3'b001;
        start = 1'b1;
        step();
        start = 1'b0;
        check("wait_busy", busy, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 10);
            if (out_valid || la_read_addr != 0 || !busy) bad++;
            step();
        end
        start = 1'b0;
        check("wait_idle_violations", bad, 0);

        la_status = 3'b100;
        step();
        check("fetch_valid", out_valid, 0);
        check("fetch_addr", la_read_addr, 0);
        step();
        check("latch_valid", out_valid, 0);
        step();
        check("first_valid", out_valid, 1);
        check("first_data", out_data, exp_beat(0));
        check("first_beat_index", beat_index, 0);
        run_stream(1'b0, -1, 1'b0, -1, nb);
        check_complete("run1");

        // Re-run from COMPLETE: capture reset first, so it must wait for DONE again
        la_status = 3'b000;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rerun_done_drop", done, 0);
        check("rerun_busy", busy, 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) bad++;
            step();
        end
        check("rerun_wait_violations", bad, 0);
        la_status = 3'b100;
        run_stream(1'b1, -1, 1'b1, 50, nb);
        check_complete("run2");

        // Abort on beat 100 while a transfer is being offered
        la_status = 3'b100;
        start = 1'b1;
        step();
        start = 1'b0;
        run_stream(1'b0, 100, 1'b0, -1, nb);
        check("abort_pre_index", beat_index, 100);
        check("abort_pre_count", nb, 100);
        out_ready = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_beat_index", beat_index, 0);
        check("abort_addr", la_read_addr, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1;
            if (out_valid || busy) bad++;
            step();
        end
        check("abort_quiet_violations", bad, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_stream(1'b0, -1, 1'b0, -1, nb);
        check_complete("replay");

        // Asynchronous reset at word 5 lane 3, observed before the next clock edge
        start = 1'b1;
        step();
        start = 1'b0;
        run_stream(1'b0, 43, 1'b0, -1, nb);
        check("prereset_valid", out_valid, 1);
        check("prereset_addr", la_read_addr, 5);
        #1 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_addr", la_read_addr, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_beat_index", beat_index, 0);
        check("async_rst_data", out_data, 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
